// File: rtl/scan_select_gen_if.sv
// Scan select bus: control/data from the host side, decoder select and
// display-qualify signals back from the scan generator.
interface scan_select_gen_if;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic        a;
  logic        b;
  logic [3:0]  digit;
  logic        valid;
  logic        tick;

  modport master (output en, load, data_in, input a, b, digit, valid, tick);
  modport slave  (input en, load, data_in, output a, b, digit, valid, tick);
endinterface

// File: rtl/scan_select_gen.sv
// Multiplexed 4-slot scan generator. A prescaler splits each slot into a
// blanking window followed by a display window; new data loaded while
// scanning is parked in a shadow register and swapped in only at the
// frame boundary so a frame never mixes old and new digits.
module scan_select_gen #(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_select_gen_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          wrap, frame_end;

  // Next-state: prescaler, slot index, FSM and the active/shadow handoff.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    wrap      = (cnt_q == LAST);
    frame_end = wrap && (sel_q == 2'd3);
    cnt_inc   = wrap ? '0 : cnt_q + CW'(1);
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (bus.en) state_d = (BLANK == 0) ? S_SHOW : S_BLANK;
      // Not scanning, so a load can land straight in the active register.
      if (bus.load) active_d = bus.data_in;
    end else if (!bus.en) begin
      // Freeze: slot restarts from the beginning when re-enabled.
      state_d = S_IDLE;
      cnt_d   = '0;
      if (bus.load) begin
        active_d = bus.data_in;
        pend_d   = 1'b0;
      end
    end else begin
      cnt_d   = cnt_inc;
      state_d = (int'(cnt_inc) < BLANK) ? S_BLANK : S_SHOW;
      if (wrap) begin
        sel_d  = sel_q + 2'd1;
        tick_d = 1'b1;
      end
      if (frame_end && bus.load) begin
        // A fresh load at the boundary supersedes anything parked.
        active_d = bus.data_in;
        pend_d   = 1'b0;
      end else if (frame_end && pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end else if (bus.load) begin
        shadow_d = bus.data_in;
        pend_d   = 1'b1;
      end
    end
  end

  // State registers; reset drops any parked data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.a     = sel_q[1];
  assign bus.b     = sel_q[0];
  assign bus.digit = active_q[{sel_q, 2'b00} +: 4];
  assign bus.valid = (state_q == S_SHOW);
  assign bus.tick  = tick_q;
endmodule

// File: tb/tb_scan_select_gen.sv
// Directed bench: DIV=4/BLANK=1 instance for the main scan, load, freeze and
// reset scenarios, plus a DIV=2/BLANK=0 instance for the no-blank case.
module tb_scan_select_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  scan_select_gen_if bus ();
  scan_select_gen_if bus2 ();

  scan_select_gen #(.DIV(4), .BLANK(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  scan_select_gen #(.DIV(2), .BLANK(0)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check slot select, digit, valid and tick for one cycle.
  task automatic chk_out(input string tag, input int s, input logic [3:0] d,
                         input logic v, input logic t);
    chk({tag, ".ab"}, {14'd0, bus.a, bus.b}, 16'(s));
    chk({tag, ".digit"}, {12'd0, bus.digit}, {12'd0, d});
    chk({tag, ".valid"}, {15'd0, bus.valid}, {15'd0, v});
    chk({tag, ".tick"}, {15'd0, bus.tick}, {15'd0, t});
  endtask

  initial begin
    logic [15:0] data;
    int s;
    bus.en = 1'b0; bus.load = 1'b0; bus.data_in = '0;
    bus2.en = 1'b0; bus2.load = 1'b0; bus2.data_in = '0;

    // Reset state
    #3;
    chk_out("reset", 0, 4'h0, 1'b0, 1'b0);
    #9 rst_n = 1'b1; rst2_n = 1'b1;

    // IDLE load goes straight to active
    step();
    bus.load = 1'b1; bus.data_in = 16'h4321;
    step();
    bus.load = 1'b0;
    chk_out("idle_load", 0, 4'h1, 1'b0, 1'b0);
    bus.en = 1'b1;

    // Full frame plus wrap: i counts edges since enabling
    for (int i = 0; i <= 20; i++) begin
      step();
      s = (i / 4) % 4;
      data = 16'h4321;
      chk_out($sformatf("run%0d", i), s, data[4*s +: 4], (i % 4) != 0,
              (i % 4 == 0) && (i >= 4));
    end

    // Load at sel=1 is parked until the next frame
    bus.load = 1'b1; bus.data_in = 16'hABCD;
    for (int i = 21; i <= 47; i++) begin
      step();
      if (i == 21) begin
        bus.load = 1'b0;
        chk("pend_set", {15'd0, u_dut.pend_q}, 16'd1);
      end
      s = (i / 4) % 4;
      data = (i >= 32) ? 16'hABCD : 16'h4321;
      chk($sformatf("shadow%0d.digit", i), {12'd0, bus.digit}, {12'd0, data[4*s +: 4]});
      if (i == 32) chk("pend_clr", {15'd0, u_dut.pend_q}, 16'd0);
    end

    // Load coincident with the 3->0 wrap
    bus.load = 1'b1; bus.data_in = 16'h00F0;
    for (int i = 48; i <= 57; i++) begin
      step();
      bus.load = 1'b0;
      s = (i / 4) % 4;
      data = 16'h00F0;
      chk_out($sformatf("wrapload%0d", i), s, data[4*s +: 4], (i % 4) != 0, (i % 4) == 0);
      chk($sformatf("wrapload%0d.pend", i), {15'd0, u_dut.pend_q}, 16'd0);
    end

    // Freeze for 5 edges mid-slot at sel=2
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("freeze%0d", i), 2, 4'h0, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("resume%0d", i), 2, 4'h0, i != 0, 1'b0);
    end
    step();
    chk_out("resume_wrap", 3, 4'h0, 1'b0, 1'b1);

    // Park data at sel=3, then reset asynchronously during SHOW
    bus.load = 1'b1; bus.data_in = 16'h1234;
    step();
    bus.load = 1'b0;
    step();
    chk_out("pre_rst", 3, 4'h0, 1'b1, 1'b0);
    chk("pre_rst.pend", {15'd0, u_dut.pend_q}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 4'h0, 1'b0, 1'b0);
    chk("async_rst.pend", {15'd0, u_dut.pend_q}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      chk_out($sformatf("post_rst%0d", i), (i / 4) % 4, 4'h0, (i % 4) != 0,
              (i % 4 == 0) && (i >= 4));
    end

    // No blanking, two-cycle slots
    bus2.en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("nb%0d.valid", j), {15'd0, bus2.valid}, 16'd1);
      chk($sformatf("nb%0d.ab", j), {14'd0, bus2.a, bus2.b}, 16'((j / 2) % 4));
      chk($sformatf("nb%0d.tick", j), {15'd0, bus2.tick}, {15'd0, (j % 2 == 0) && (j > 0)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_select_gen.md
SCAN_SELECT_GEN -- requirements
Module: scan_select_gen

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clock cycles per scan slot; legal range 2..256.
REQ-002 The block SHALL have parameter BLANK, default 1, meaning blanking cycles at the start of each slot; legal range 0..DIV-1.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  scan enable; 0 = freeze scanning.
REQ-006 Port load  input  1  one-cycle strobe to capture data_in.
REQ-007 Port data_in  input  16  four 4-bit slot values; slot k = data_in[4k+3:4k].
REQ-008 Port a  output  1  select MSB, drives the 2-to-4 decoder a input.
REQ-009 Port b  output  1  select LSB, drives the 2-to-4 decoder b input.
REQ-010 Port digit  output  4  value of the slot currently selected.
REQ-011 Port valid  output  1  high when the selected slot may be displayed (decoder outputs used as enables).
REQ-012 Port tick  output  1  one-cycle pulse marking a slot change.

Function
REQ-013 The block SHALL keep a 2-bit slot index sel, with {a,b} = sel at all times.
REQ-014 The block SHALL keep a prescale counter cnt (0..DIV-1) and an FSM with states IDLE, BLANK, SHOW.
REQ-015 IDLE: cnt held at 0, sel held, valid=0, tick=0. The FSM moves to BLANK (or SHOW if BLANK=0) on the first edge with en=1.
REQ-016 BLANK/SHOW: cnt increments by 1 each cycle. On cnt==DIV-1 it wraps to 0, sel increments mod 4 (3 wraps to 0), and tick is 1 in the following cycle only.
REQ-017 The FSM SHALL be in BLANK while cnt<BLANK and in SHOW while cnt>=BLANK. valid=1 exactly in SHOW.
REQ-018 en=0 seen in BLANK/SHOW SHALL move the FSM to IDLE on that edge: cnt set to 0, sel unchanged, no tick.
REQ-019 Slot period SHALL be exactly DIV cycles. The frame period (sel 0..3) SHALL be 4*DIV cycles.
REQ-020 The block SHALL hold a 16-bit active register and a 16-bit shadow register plus a pending flag.
REQ-021 digit SHALL equal active[4*sel+3:4*sel], combinationally from registered state.
REQ-022 load=1 in IDLE SHALL write data_in directly to active; shadow and pending are untouched.
REQ-023 load=1 in BLANK/SHOW SHALL write data_in to shadow and set pending. A later load before transfer overwrites shadow (last wins).
REQ-024 On the edge where sel wraps 3->0 with pending=1, shadow SHALL be copied to active and pending cleared, so a frame never mixes old and new data.
REQ-025 load=1 on the same edge as a 3->0 wrap SHALL write data_in straight to active and clear pending.
REQ-026 load=1 on the same edge as en falling SHALL be treated as an IDLE load (direct to active, pending cleared).

Reset
REQ-027 rst_n=0 SHALL immediately force: cnt=0, sel=0 (a=0, b=0), active=0, shadow=0, pending=0, state IDLE, valid=0, tick=0, digit=0.
REQ-028 Reset asserted mid-slot or mid-frame SHALL discard pending data. After release the block behaves as after power-up.
REQ-029 The first active edge after rst_n rises SHALL be treated as a normal edge (en sampled).

Verification
REQ-030 DIV=4, BLANK=1. Reset, then load=1 with data_in=16'h4321 in IDLE, then en=1 -> digit sequence 1,2,3,4,1 with {a,b}=00,01,10,11,00. Each slot lasts 4 cycles, valid pattern 0,1,1,1 per slot, tick once per slot.
REQ-031 While running, load 16'hABCD when sel=1 -> digits stay 1..4 for slots 1..3, become D,C,B,A from the next sel=0, and pending clears at that wrap.
REQ-032 Load coincident with the 3->0 wrap edge, data 16'h00F0 -> slot 0 shows 0 immediately, slot 1 shows F, and pending stays 0.
REQ-033 Drop en for 5 cycles mid-slot at sel=2 -> valid=0 and sel held at 2 with no tick. On re-enable the slot restarts from cnt=0 and a full 4-cycle slot 2 follows.
REQ-034 Assert rst_n=0 asynchronously (between clock edges) during SHOW at sel=3 with pending=1 -> a, b, digit, valid and tick go to 0 without a clock edge. After release, with en=1 and no load, digit=0 in all slots.
REQ-035 BLANK=0 and DIV=2 -> valid stays 1 continuously while en=1, and sel advances every 2 cycles.
